aes_arbiter: RTL and testbench

Two-requester front end for the AES decryption core. Accepts a key and ciphertext from either requester over a valid/ready handshake, grants the single core round-robin, and sequences its START/DONE protocol. Captures the plaintext and returns it to the owning requester over a valid/ready response channel. Sits between the bus-side register interfaces and the AES core instance; it is the only driver of the core's START, KEY and MSG_ENC inputs.

---
 rtl/aes_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_aes_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_arbiter.sv
// aes_arbiter: two-requester front end for a single AES decryption core.
//
// Jobs (key + ciphertext) arrive on REQ0/REQ1 valid/ready channels and are
// granted round-robin. The arbiter then runs the core START/DONE protocol,
// captures the plaintext and returns it to the owner on RSP0/RSP1.
//
// Handshake rule for every channel: a transfer happens on a rising CLK edge
// where VALID and READY are both high. A producer holds VALID and its payload
// stable until that edge. The producer never lowers VALID early. The consumer
// may raise or lower READY freely.
//
// Optional feature:
//   AES_ARB_TIMEOUT_EN  run watchdog that aborts a job after TIMEOUT_CYCLES
//                       RUN cycles. The response then carries ERR = 1 and
//                       DATA = 0. When the macro is undefined, RUN waits
//                       indefinitely and RSPx_ERR are tied to 0.
//
// Ports:
//   CLK, RESET                     clock, synchronous active-high reset
//   REQx_VALID/READY/KEY/MSG       job request channels (x = 0, 1)
//   RSPx_VALID/READY/DATA/ERR      response channels (DATA is shared)
//   AES_START/DONE/KEY/MSG_ENC/MSG_DEC   core interface
//   BUSY, GRANT_ID, JOB_COUNT      status
//   DBG_STATE                      FSM state (0 IDLE, 1 RUN, 2 RELEASE, 3 RESP)
//   JOB_COUNT_LOAD/_VALUE          diagnostic preload of JOB_COUNT
module aes_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         REQ0_VALID,
  output logic         REQ0_READY,
  input  logic [127:0] REQ0_KEY,
  input  logic [127:0] REQ0_MSG,
  input  logic         REQ1_VALID,
  output logic         REQ1_READY,
  input  logic [127:0] REQ1_KEY,
  input  logic [127:0] REQ1_MSG,
  output logic         RSP0_VALID,
  input  logic         RSP0_READY,
  output logic [127:0] RSP0_DATA,
  output logic         RSP0_ERR,
  output logic         RSP1_VALID,
  input  logic         RSP1_READY,
  output logic [127:0] RSP1_DATA,
  output logic         RSP1_ERR,
  output logic         AES_START,
  input  logic         AES_DONE,
  output logic [127:0] AES_KEY,
  output logic [127:0] AES_MSG_ENC,
  input  logic [127:0] AES_MSG_DEC,
  output logic         BUSY,
  output logic         GRANT_ID,
  output logic [15:0]  JOB_COUNT,
  output logic [1:0]   DBG_STATE,
  input  logic         JOB_COUNT_LOAD,
  input  logic [15:0]  JOB_COUNT_LOAD_VALUE
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_RELEASE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  // The watchdog needs at least two RUN cycles to be meaningful.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    $error("aes_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  state_t       state;
  logic         ptr;        // requester favoured when both are valid
  logic         owner;      // GRANT_ID register
  logic [127:0] key_q;
  logic [127:0] msg_q;
  logic [127:0] result_q;
  logic [15:0]  job_count;
  logic         grant;
  logic         accept;
  logic         rsp_fire;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] RUN_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] run_cnt;
  logic          err_q;
`endif

  // A lone VALID wins outright. With both valid, the pointer decides.
  always_comb begin
    grant = ptr;
    if (REQ0_VALID && !REQ1_VALID) begin
      grant = 1'b0;
    end else if (REQ1_VALID && !REQ0_VALID) begin
      grant = 1'b1;
    end
  end

  assign REQ0_READY = (state == S_IDLE) && REQ0_VALID && (grant == 1'b0);
  assign REQ1_READY = (state == S_IDLE) && REQ1_VALID && (grant == 1'b1);
  assign accept     = (state == S_IDLE) && (REQ0_VALID || REQ1_VALID);
  assign rsp_fire   = (state == S_RESP) && (owner ? RSP1_READY : RSP0_READY);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      key_q     <= '0;
      msg_q     <= '0;
      result_q  <= '0;
      job_count <= '0;
`ifdef AES_ARB_TIMEOUT_EN
      run_cnt   <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            key_q <= grant ? REQ1_KEY : REQ0_KEY;
            msg_q <= grant ? REQ1_MSG : REQ0_MSG;
            owner <= grant;
            ptr   <= ~grant;
            state <= S_RUN;
`ifdef AES_ARB_TIMEOUT_EN
            run_cnt <= '0;
`endif
          end
        end
        S_RUN: begin
          if (AES_DONE) begin
            result_q <= AES_MSG_DEC;
`ifdef AES_ARB_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
            state    <= S_RELEASE;
          end
`ifdef AES_ARB_TIMEOUT_EN
          else if (run_cnt == RUN_LAST) begin
            // Abort: report the error with a zeroed result.
            err_q    <= 1'b1;
            result_q <= '0;
            state    <= S_RELEASE;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
`endif
        end
        // Wait for the core to drop DONE so it is idle before the next job.
        S_RELEASE: begin
          if (!AES_DONE) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_fire) begin
            job_count <= job_count + 16'd1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // The diagnostic preload overrides any same-cycle increment.
      if (JOB_COUNT_LOAD) begin
        job_count <= JOB_COUNT_LOAD_VALUE;
      end
    end
  end

  assign AES_START   = (state == S_RUN);
  assign AES_KEY     = key_q;
  assign AES_MSG_ENC = msg_q;
  assign RSP0_VALID  = (state == S_RESP) && (owner == 1'b0);
  assign RSP1_VALID  = (state == S_RESP) && (owner == 1'b1);
  assign RSP0_DATA   = result_q;
  assign RSP1_DATA   = result_q;
`ifdef AES_ARB_TIMEOUT_EN
  assign RSP0_ERR    = RSP0_VALID && err_q;
  assign RSP1_ERR    = RSP1_VALID && err_q;
`else
  assign RSP0_ERR    = 1'b0;
  assign RSP1_ERR    = 1'b0;
`endif
  assign BUSY        = (state != S_IDLE);
  assign GRANT_ID    = owner;
  assign JOB_COUNT   = job_count;
  assign DBG_STATE   = state;

endmodule

// File: tb/tb_aes_arbiter.sv
// Directed testbench for aes_arbiter with a behavioural AES core model.
// The core model raises DONE core_lat+1 cycles into START and holds DONE
// until START falls. For the FIPS-197 vector it returns the published
// plaintext. For any other input it returns an easily predicted scramble.
module tb_aes_arbiter;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K0 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] M0 = 128'hdead_beef_0000_ffff_0123_4567_89ab_cdef;
  localparam logic [127:0] K1 = 128'ha5a5_5a5a_0f0f_f0f0_1234_5678_9abc_def0;
  localparam logic [127:0] M1 = 128'hcafe_f00d_8badf00d_1357_9bdf_2468_ace0;

  logic         CLK = 0, RESET = 1;
  logic         REQ0_VALID = 0, REQ1_VALID = 0, RSP0_READY = 0, RSP1_READY = 0;
  logic [127:0] REQ0_KEY = '0, REQ0_MSG = '0, REQ1_KEY = '0, REQ1_MSG = '0;
  logic         REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, RSP0_ERR, RSP1_ERR;
  logic [127:0] RSP0_DATA, RSP1_DATA, AES_KEY, AES_MSG_ENC, AES_MSG_DEC;
  logic         AES_START, AES_DONE, BUSY, GRANT_ID;
  logic [15:0]  JOB_COUNT;
  logic [1:0]   DBG_STATE;
  logic         JOB_COUNT_LOAD = 0;
  logic [15:0]  JOB_COUNT_LOAD_VALUE = '0;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  aes_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_KEY(REQ0_KEY), .REQ0_MSG(REQ0_MSG),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_KEY(REQ1_KEY), .REQ1_MSG(REQ1_MSG),
    .RSP0_VALID(RSP0_VALID), .RSP0_READY(RSP0_READY), .RSP0_DATA(RSP0_DATA), .RSP0_ERR(RSP0_ERR),
    .RSP1_VALID(RSP1_VALID), .RSP1_READY(RSP1_READY), .RSP1_DATA(RSP1_DATA), .RSP1_ERR(RSP1_ERR),
    .AES_START(AES_START), .AES_DONE(AES_DONE), .AES_KEY(AES_KEY),
    .AES_MSG_ENC(AES_MSG_ENC), .AES_MSG_DEC(AES_MSG_DEC),
    .BUSY(BUSY), .GRANT_ID(GRANT_ID), .JOB_COUNT(JOB_COUNT), .DBG_STATE(DBG_STATE),
    .JOB_COUNT_LOAD(JOB_COUNT_LOAD), .JOB_COUNT_LOAD_VALUE(JOB_COUNT_LOAD_VALUE)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- core model ----------------
  logic         core_en = 1;
  int           core_lat = 3;
  logic         done_force = 0;
  logic         done_q = 0;
  logic [127:0] dec_q = '0;
  int           core_cnt = 0;

  function automatic logic [127:0] plain_of(input logic [127:0] k, input logic [127:0] m);
    if (k == FIPS_KEY && m == FIPS_CT) return FIPS_PT;
    return k ^ {m[63:0], m[127:64]};
  endfunction

  always @(posedge CLK) begin
    if (!AES_START) begin
      done_q   <= 1'b0;
      core_cnt <= 0;
    end else if (core_en && !done_q) begin
      if (core_cnt == core_lat) begin
        done_q <= 1'b1;
        dec_q  <= plain_of(AES_KEY, AES_MSG_ENC);
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end
  end
  assign AES_DONE    = done_q | done_force;
  assign AES_MSG_DEC = dec_q;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge CLK);
    RESET = 1;
    REQ0_VALID = 0; REQ1_VALID = 0; RSP0_READY = 0; RSP1_READY = 0;
    repeat (2) @(negedge CLK);
    RESET = 0;
  endtask

  // Called at a negedge. Returns at the negedge after the accept edge with VALID dropped.
  task automatic send_req(input bit id, input logic [127:0] key, input logic [127:0] msg,
                          output bit ok);
    ok = 0;
    if (id) begin REQ1_KEY = key; REQ1_MSG = msg; REQ1_VALID = 1; end
    else    begin REQ0_KEY = key; REQ0_MSG = msg; REQ0_VALID = 1; end
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      if (id ? REQ1_READY : REQ0_READY) ok = 1;
      @(negedge CLK);
    end
    if (id) REQ1_VALID = 0; else REQ0_VALID = 0;
  endtask

  // Returns 1 ns after a negedge where the RSP VALID of requester id is high.
  task automatic wait_rsp(input bit id, output bit ok);
    ok = 0;
    #1;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (id ? RSP1_VALID : RSP0_VALID) ok = 1;
      else begin @(negedge CLK); #1; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge CLK);
    RESET = 0;
    #1;
    checks++; if (REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b expected 00", REQ0_READY, REQ1_READY); end
    checks++; if (RSP0_VALID !== 1'b0 || RSP1_VALID !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b%b expected 00", RSP0_VALID, RSP1_VALID); end
    checks++; if (RSP0_ERR !== 1'b0 || RSP1_ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b%b expected 00", RSP0_ERR, RSP1_ERR); end
    checks++; if (AES_START !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", AES_START); end
    checks++; if (AES_KEY !== '0 || AES_MSG_ENC !== '0) begin errors++; $display("FAIL reset_core_bus: got %h/%h expected 0", AES_KEY, AES_MSG_ENC); end
    checks++; if (RSP0_DATA !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", RSP0_DATA); end
    checks++; if (BUSY !== 1'b0 || GRANT_ID !== 1'b0) begin errors++; $display("FAIL reset_busy_grant: got %b%b expected 00", BUSY, GRANT_ID); end
    checks++; if (JOB_COUNT !== 16'h0) begin errors++; $display("FAIL reset_job_count: got %h expected 0000", JOB_COUNT); end
    checks++; if (DBG_STATE !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", DBG_STATE); end
  endtask

  task automatic test_single();
    bit ok, got, rsp1_seen;
    int nd;
    @(negedge CLK);
    RSP0_READY = 1;
    send_req(0, FIPS_KEY, FIPS_CT, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_accept: got no accept expected accept"); end
    #1;
    checks++; if (AES_START !== 1'b1 || BUSY !== 1'b1) begin errors++; $display("FAIL single_start: got start=%b busy=%b expected 1 1", AES_START, BUSY); end
    checks++; if (AES_KEY !== FIPS_KEY || AES_MSG_ENC !== FIPS_CT) begin errors++; $display("FAIL single_core_bus: got %h/%h expected %h/%h", AES_KEY, AES_MSG_ENC, FIPS_KEY, FIPS_CT); end
    got = 0; rsp1_seen = 0; nd = -1;
    for (int n = 0; n < 100 && !got; n++) begin
      if (RSP1_VALID) rsp1_seen = 1;
      if (AES_DONE && nd < 0) nd = n;
      if (nd >= 0 && n == nd + 1) begin
        checks++; if (DBG_STATE !== 2'd2) begin errors++; $display("FAIL single_release: got state %0d expected 2", DBG_STATE); end
      end
      if (RSP0_VALID) begin
        got = 1;
        // DONE stays high one cycle into RELEASE, so VALID lands at k+3 here.
        checks++; if (n != nd + 3) begin errors++; $display("FAIL single_rsp_latency: got %0d expected %0d", n, nd + 3); end
        checks++; if (RSP0_DATA !== FIPS_PT || RSP0_ERR !== 1'b0) begin errors++; $display("FAIL single_data: got %h err %b expected %h err 0", RSP0_DATA, RSP0_ERR, FIPS_PT); end
      end else begin
        @(negedge CLK); #1;
      end
    end
    checks++; if (!got) begin errors++; $display("FAIL single_rsp_timeout: got no RSP0_VALID expected RSP0_VALID"); end
    @(negedge CLK); #1;
    RSP0_READY = 0;
    checks++; if (JOB_COUNT !== 16'd1 || GRANT_ID !== 1'b0) begin errors++; $display("FAIL single_count: got count %h grant %b expected 0001 0", JOB_COUNT, GRANT_ID); end
    checks++; if (RSP0_VALID !== 1'b0 || DBG_STATE !== 2'd0 || BUSY !== 1'b0) begin errors++; $display("FAIL single_idle: got valid %b state %0d busy %b expected 0 0 0", RSP0_VALID, DBG_STATE, BUSY); end
    checks++; if (rsp1_seen) begin errors++; $display("FAIL single_rsp1: got RSP1_VALID high expected never"); end
  endtask

  task automatic test_done_ignored_idle();
    @(negedge CLK);
    done_force = 1;
    repeat (4) @(negedge CLK);
    #1;
    checks++; if (DBG_STATE !== 2'd0 || BUSY !== 1'b0) begin errors++; $display("FAIL done_in_idle: got state %0d busy %b expected 0 0", DBG_STATE, BUSY); end
    done_force = 0;
  endtask

  task automatic test_contention();
    bit owner_q[$];
    bit grants[$];
    bit exp_grant[4];
    int rsp_n, overlap;
    logic [127:0] exp_d;
    bit owner;
    exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    REQ0_KEY = K0; REQ0_MSG = M0; REQ1_KEY = K1; REQ1_MSG = M1;
    REQ0_VALID = 1; REQ1_VALID = 1; RSP0_READY = 1; RSP1_READY = 1;
    rsp_n = 0; overlap = 0;
    for (int c = 0; c < 300 && rsp_n < 4; c++) begin
      #1;
      if ((REQ0_READY || REQ1_READY) && (RSP0_VALID || RSP1_VALID)) overlap++;
      if (REQ0_READY) begin grants.push_back(1'b0); owner_q.push_back(1'b0); exp_q.push_back(plain_of(K0, M0)); end
      if (REQ1_READY) begin grants.push_back(1'b1); owner_q.push_back(1'b1); exp_q.push_back(plain_of(K1, M1)); end
      if (RSP0_VALID || RSP1_VALID) begin
        exp_d = exp_q.pop_front();
        owner = owner_q.pop_front();
        checks++; if (RSP1_VALID !== owner || (RSP1_VALID ? RSP1_DATA : RSP0_DATA) !== exp_d) begin
          errors++; $display("FAIL contention_rsp%0d: got id %b data %h expected id %b data %h", rsp_n, RSP1_VALID, RSP0_DATA, owner, exp_d);
        end
        rsp_n++;
        if (rsp_n == 4) begin REQ0_VALID = 0; REQ1_VALID = 0; end
      end
      @(negedge CLK);
    end
    RSP0_READY = 0; RSP1_READY = 0;
    checks++; if (rsp_n != 4 || grants.size() < 4) begin errors++; $display("FAIL contention_count: got %0d rsps %0d grants expected 4 4", rsp_n, grants.size()); end
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      checks++; if (grants[i] !== exp_grant[i]) begin errors++; $display("FAIL contention_grant%0d: got %b expected %b", i, grants[i], exp_grant[i]); end
    end
    checks++; if (overlap != 0) begin errors++; $display("FAIL contention_overlap: got %0d expected 0", overlap); end
    checks++; if (JOB_COUNT !== 16'd4) begin errors++; $display("FAIL contention_job_count: got %h expected 0004", JOB_COUNT); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [127:0] exp_d;
    exp_d = plain_of(K1, M1);
    @(negedge CLK);
    RSP1_READY = 0;
    send_req(1, K1, M1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_accept: got no accept expected accept"); end
    REQ0_KEY = K0; REQ0_MSG = M0; REQ0_VALID = 1;
    wait_rsp(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_rsp_timeout: got no RSP1_VALID expected RSP1_VALID"); end
    done_force = 1;  // DONE during RESP must change nothing
    for (int i = 0; i < 20; i++) begin
      checks++; if (RSP1_VALID !== 1'b1 || RSP1_DATA !== exp_d || RSP1_ERR !== 1'b0) begin errors++; $display("FAIL bp_hold%0d: got v%b %h e%b expected v1 %h e0", i, RSP1_VALID, RSP1_DATA, RSP1_ERR, exp_d); end
      checks++; if (REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0 || BUSY !== 1'b1) begin errors++; $display("FAIL bp_ready%0d: got r%b%b busy %b expected r00 busy 1", i, REQ0_READY, REQ1_READY, BUSY); end
      @(negedge CLK); #1;
    end
    done_force = 0;
    RSP1_READY = 1;
    @(negedge CLK); #1;
    RSP1_READY = 0;
    checks++; if (RSP1_VALID !== 1'b0 || JOB_COUNT !== 16'd5) begin errors++; $display("FAIL bp_release: got valid %b count %h expected 0 0005", RSP1_VALID, JOB_COUNT); end
    checks++; if (REQ0_READY !== 1'b1) begin errors++; $display("FAIL bp_next_grant: got REQ0_READY %b expected 1", REQ0_READY); end
    REQ0_VALID = 0;
  endtask

  task automatic test_reset_mid_run();
    bit ok, seen;
    @(negedge CLK);
    core_lat = 20;
    send_req(0, K0, M0, ok);
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (!ok || DBG_STATE !== 2'd1 || JOB_COUNT !== 16'd5) begin errors++; $display("FAIL midrun_pre: got ok %b state %0d count %h expected 1 1 0005", ok, DBG_STATE, JOB_COUNT); end
    @(negedge CLK);
    RESET = 1;
    @(negedge CLK);
    RESET = 0;
    #1;
    checks++; if (AES_START !== 1'b0 || DBG_STATE !== 2'd0 || JOB_COUNT !== 16'd0) begin errors++; $display("FAIL midrun_reset: got start %b state %0d count %h expected 0 0 0000", AES_START, DBG_STATE, JOB_COUNT); end
    RSP0_READY = 1; RSP1_READY = 1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (RSP0_VALID || RSP1_VALID) seen = 1;
      @(negedge CLK); #1;
    end
    RSP0_READY = 0; RSP1_READY = 0;
    checks++; if (seen) begin errors++; $display("FAIL midrun_no_rsp: got RSP_VALID expected none"); end
    core_lat = 3;
  endtask

`ifdef AES_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int runs;
    @(negedge CLK);
    core_en = 0;
    send_req(0, K0, M0, ok);
    runs = 0;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (!AES_START) break;
      runs++;
      @(negedge CLK);
    end
    checks++; if (runs != 16) begin errors++; $display("FAIL timeout_run_cycles: got %0d expected 16", runs); end
    wait_rsp(0, ok);
    checks++; if (!ok || RSP0_ERR !== 1'b1 || RSP0_DATA !== '0) begin errors++; $display("FAIL timeout_rsp: got ok %b err %b data %h expected 1 1 0", ok, RSP0_ERR, RSP0_DATA); end
    RSP0_READY = 1;
    @(negedge CLK);
    RSP0_READY = 0;
    core_en = 1;
  endtask
`else
  task automatic test_run_waits();
    bit ok;
    @(negedge CLK);
    core_en = 0;
    send_req(0, K0, M0, ok);
    repeat (40) @(negedge CLK);
    #1;
    checks++; if (!ok || AES_START !== 1'b1 || DBG_STATE !== 2'd1) begin errors++; $display("FAIL run_waits: got ok %b start %b state %0d expected 1 1 1", ok, AES_START, DBG_STATE); end
    checks++; if (RSP0_ERR !== 1'b0 || RSP1_ERR !== 1'b0) begin errors++; $display("FAIL err_tied: got %b%b expected 00", RSP0_ERR, RSP1_ERR); end
    core_en = 1;
    do_reset();
  endtask
`endif

  task automatic test_wrap();
    bit ok;
    @(negedge CLK);
    JOB_COUNT_LOAD = 1; JOB_COUNT_LOAD_VALUE = 16'hFFFF;
    @(negedge CLK);
    JOB_COUNT_LOAD = 0;
    #1;
    checks++; if (JOB_COUNT !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffff", JOB_COUNT); end
    @(negedge CLK);
    RSP1_READY = 1;
    send_req(1, K1, M1, ok);
    wait_rsp(1, ok);
    checks++; if (!ok || RSP1_DATA !== plain_of(K1, M1)) begin errors++; $display("FAIL wrap_rsp: got ok %b data %h expected 1 %h", ok, RSP1_DATA, plain_of(K1, M1)); end
    @(negedge CLK); #1;
    RSP1_READY = 0;
    checks++; if (JOB_COUNT !== 16'h0000) begin errors++; $display("FAIL wrap_count: got %h expected 0000", JOB_COUNT); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_done_ignored_idle();
    test_contention();
    test_backpressure();
    test_reset_mid_run();
`ifdef AES_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_run_waits();
`endif
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
